// File: rtl/cpu_bus_seq.sv
// T80 bus sequencer: clock enables, per-cycle wait states, bounded INT_n.
// Optional half-period turbo mode when CPU_BUS_SEQ_TURBO_EN is defined.
module cpu_bus_seq #(
  parameter int DIV      = 4,
  parameter int MEM_WAIT = 0,
  parameter int IO_WAIT  = 1,
  parameter int IRQ_LEN  = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic hold,
`ifdef CPU_BUS_SEQ_TURBO_EN
  input  logic turbo,
`endif
  input  logic irq_req,
  input  logic mreq,
  input  logic iorq,
  input  logic m1,
  input  logic rfsh,
  output logic pe,
  output logic ne,
  output logic wait_n,
  output logic irq
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] FULL_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] FULL_HALF = CW'(DIV / 2 - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] last;
  logic [CW-1:0] half;

`ifdef CPU_BUS_SEQ_TURBO_EN
  localparam logic [CW-1:0] FAST_LAST = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FAST_HALF = CW'(DIV / 4 - 1);

  logic tq;
  logic fast;

  // Mode only switches at the start of a period.
  assign fast = (cnt == '0) ? turbo : tq;
  assign last = fast ? FAST_LAST : FULL_LAST;
  assign half = fast ? FAST_HALF : FULL_HALF;

  always_ff @(posedge clock) begin
    if (reset)
      tq <= 1'b0;
    else if (cnt == '0)
      tq <= turbo;
  end
`else
  assign last = FULL_LAST;
  assign half = FULL_HALF;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
      pe  <= 1'b0;
      ne  <= 1'b0;
    end else begin
      pe <= ~hold & (cnt == last);
      ne <= ~hold & (cnt == half);
      if (!hold)
        cnt <= (cnt == last) ? '0 : cnt + 1'b1;
    end
  end

  logic       pmreq;
  logic       piorq;
  logic [3:0] wcnt;
  logic [3:0] wnext;

  always_comb begin
    wnext = wcnt;
    if (~mreq & rfsh & pmreq)
      wnext = 4'(MEM_WAIT);
    else if (~iorq & m1 & piorq)
      wnext = 4'(IO_WAIT);
    else if (wcnt != 4'd0)
      wnext = wcnt - 4'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wcnt   <= 4'd0;
      wait_n <= 1'b1;
      pmreq  <= 1'b1;
      piorq  <= 1'b1;
    end else if (pe) begin
      wcnt   <= wnext;
      wait_n <= (wnext == 4'd0);
      pmreq  <= mreq;
      piorq  <= iorq;
    end
  end

  logic       pending;
  logic       pnext;
  logic [7:0] icnt;
  logic [7:0] inext;

  // A new request outranks a same-clock acknowledge.
  always_comb begin
    pnext = pending;
    inext = icnt;
    if (irq_req) begin
      pnext = 1'b1;
      inext = 8'(IRQ_LEN);
    end else if (~m1 & ~iorq) begin
      pnext = 1'b0;
    end else if (pe & pending) begin
      inext = icnt - 8'd1;
      if (icnt == 8'd1)
        pnext = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= 1'b0;
      icnt    <= 8'd0;
      irq     <= 1'b1;
    end else begin
      pending <= pnext;
      icnt    <= inext;
      irq     <= ~pnext;
    end
  end

endmodule

// File: tb/tb_cpu_bus_seq.sv
// Self-checking bench for cpu_bus_seq against a behavioural model.
// Model counts unheld clocks and remaining wait/interrupt ticks directly.
module tb_cpu_bus_seq;

  localparam int DIV = 4;
  localparam int MW  = 2;
  localparam int IW  = 1;
  localparam int IL  = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic hold = 1'b0;
  logic irq_req = 1'b0;
  logic mreq = 1'b1;
  logic iorq = 1'b1;
  logic m1 = 1'b1;
  logic rfsh = 1'b1;
  logic pe, ne, wait_n, irq;

  int checks = 0;
  int errors = 0;

  int n = 0;
  bit e_pe = 0, e_ne = 0, e_wait = 1, e_irq = 1;
  bit m_pm = 1, m_pio = 1, m_pend = 0;
  int m_w = 0, m_ic = 0;

  cpu_bus_seq #(
    .DIV(DIV), .MEM_WAIT(MW), .IO_WAIT(IW), .IRQ_LEN(IL)
  ) dut (
    .clock(clock),
    .reset(reset),
    .hold(hold),
`ifdef CPU_BUS_SEQ_TURBO_EN
    .turbo(1'b0),
`endif
    .irq_req(irq_req),
    .mreq(mreq),
    .iorq(iorq),
    .m1(m1),
    .rfsh(rfsh),
    .pe(pe),
    .ne(ne),
    .wait_n(wait_n),
    .irq(irq)
  );

  always #5 clock = ~clock;

  // One clock edge; model follows the spec rules, outputs settle by #1.
  task automatic step();
    bit tick;
    @(posedge clock);
    tick = e_pe;
    if (reset) begin
      n = 0; e_pe = 0; e_ne = 0; e_wait = 1; e_irq = 1;
      m_pm = 1; m_pio = 1; m_pend = 0; m_w = 0; m_ic = 0;
    end else begin
      if (!hold) n++;
      e_pe = !hold && (n % DIV == 0);
      e_ne = !hold && (n % DIV == DIV / 2);
      if (tick) begin
        if (!mreq && rfsh && m_pm) m_w = MW;
        else if (!iorq && m1 && m_pio) m_w = IW;
        else if (m_w > 0) m_w--;
        e_wait = (m_w == 0);
        m_pm = mreq;
        m_pio = iorq;
      end
      if (irq_req) begin
        m_pend = 1; m_ic = IL;
      end else if (!m1 && !iorq) begin
        m_pend = 0;
      end else if (tick && m_pend) begin
        m_ic--;
        if (m_ic == 0) m_pend = 0;
      end
      e_irq = !m_pend;
    end
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic sync_pe(input string tag);
    int g = 0;
    while (pe !== 1'b1 && g < 2 * DIV) begin
      step();
      g++;
    end
    checks++;
    if (pe !== 1'b1) begin
      errors++;
      $display("FAIL %s_sync pe=%b required 1", tag, pe);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (pe !== 1'b0) begin errors++; $display("FAIL rst_pe got %b exp 0", pe); end
    checks++;
    if (ne !== 1'b0) begin errors++; $display("FAIL rst_ne got %b exp 0", ne); end
    checks++;
    if (wait_n !== 1'b1) begin errors++; $display("FAIL rst_wait got %b exp 1", wait_n); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL rst_irq got %b exp 1", irq); end
  endtask

  task automatic test_divider();
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      checks++;
      if (pe !== (k % DIV == 0)) begin
        errors++;
        $display("FAIL div_pe edge=%0d got %b exp %b", k, pe, k % DIV == 0);
      end
      checks++;
      if (ne !== (k % DIV == DIV / 2)) begin
        errors++;
        $display("FAIL div_ne edge=%0d got %b exp %b", k, ne, k % DIV == DIV / 2);
      end
      checks++;
      if (pe === 1'b1 && ne === 1'b1) begin
        errors++;
        $display("FAIL div_both edge=%0d pe=%b ne=%b", k, pe, ne);
      end
    end
  endtask

  task automatic test_hold();
    step();
    hold = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (pe !== 1'b0 || ne !== 1'b0) begin
        errors++;
        $display("FAIL hold_quiet k=%0d pe=%b ne=%b exp 0 0", k, pe, ne);
      end
    end
    hold = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (pe !== (k % DIV == 3) || ne !== (k % DIV == 1)) begin
        errors++;
        $display("FAIL hold_resume k=%0d pe=%b ne=%b exp %b %b",
                 k, pe, ne, k % DIV == 3, k % DIV == 1);
      end
    end
  endtask

  task automatic test_wait();
    int low;
    int want [3];
    string name [3];
    want[0] = MW * DIV; want[1] = 0; want[2] = IW * DIV;
    name[0] = "wait_mem"; name[1] = "wait_rfsh"; name[2] = "wait_io";
    for (int c = 0; c < 3; c++) begin
      idle(2 * DIV);
      sync_pe(name[c]);
      mreq = (c == 2);
      rfsh = (c != 1);
      iorq = (c != 2);
      low = 0;
      for (int k = 0; k < 24; k++) begin
        step();
        if (wait_n === 1'b0) low++;
        checks++;
        if (wait_n !== e_wait) begin
          errors++;
          $display("FAIL %s_cyc k=%0d got %b exp %b", name[c], k, wait_n, e_wait);
        end
      end
      mreq = 1'b1; rfsh = 1'b1; iorq = 1'b1;
      checks++;
      if (low != want[c]) begin
        errors++;
        $display("FAIL %s_len got %0d clocks exp %0d", name[c], low, want[c]);
      end
    end
  endtask

  task automatic test_irq_timeout();
    int ticks = 0;
    irq_req = 1'b1;
    step();
    irq_req = 1'b0;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_assert got %b exp 0", irq); end
    if (pe === 1'b1 && irq === 1'b0) ticks++;
    for (int k = 0; k < 48; k++) begin
      step();
      if (pe === 1'b1 && irq === 1'b0) ticks++;
      checks++;
      if (irq !== e_irq) begin
        errors++;
        $display("FAIL irq_to_cyc k=%0d got %b exp %b", k, irq, e_irq);
      end
    end
    checks++;
    if (ticks != IL) begin errors++; $display("FAIL irq_to_len got %0d ticks exp %0d", ticks, IL); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_to_end got %b exp 1", irq); end
  endtask

  task automatic test_irq_ack();
    int seen = 0;
    int g = 0;
    irq_req = 1'b1;
    step();
    irq_req = 1'b0;
    while (seen < 3 && g < 6 * DIV) begin
      step();
      if (pe === 1'b1) seen++;
      g++;
    end
    checks++;
    if (seen != 3 || irq !== 1'b0) begin
      errors++;
      $display("FAIL ack_pre ticks=%0d irq=%b exp 3 0", seen, irq);
    end
    m1 = 1'b0; iorq = 1'b0;
    step();
    m1 = 1'b1; iorq = 1'b1;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL ack_clear got %b exp 1", irq); end
    irq_req = 1'b1; m1 = 1'b0; iorq = 1'b0;
    step();
    irq_req = 1'b0; m1 = 1'b1; iorq = 1'b1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL ack_coinc got %b exp 0", irq); end
    step();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL ack_coinc_hold got %b exp 0", irq); end
    idle(2 * DIV);
    sync_pe("ack_io");
    m1 = 1'b0; iorq = 1'b0;
    step();
    m1 = 1'b1; iorq = 1'b1;
    checks++;
    if (wait_n !== 1'b1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL ack_no_wait wait_n=%b irq=%b exp 1 1", wait_n, irq);
    end
  endtask

  task automatic test_reset_mid();
    idle(2 * DIV);
    sync_pe("rst_mid");
    mreq = 1'b0;
    step();
    irq_req = 1'b1;
    step();
    irq_req = 1'b0;
    checks++;
    if (wait_n !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_pre wait_n=%b irq=%b exp 0 0", wait_n, irq);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    mreq = 1'b1;
    checks++;
    if (wait_n !== 1'b1 || irq !== 1'b1 || pe !== 1'b0 || ne !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid wait_n=%b irq=%b pe=%b ne=%b exp 1 1 0 0",
               wait_n, irq, pe, ne);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      reset = ($urandom_range(0, 149) == 0);
      hold = ($urandom_range(0, 6) == 0);
      irq_req = ($urandom_range(0, 24) == 0);
      mreq = 1'($urandom_range(0, 1));
      rfsh = ($urandom_range(0, 3) != 0);
      iorq = ($urandom_range(0, 3) != 0);
      m1 = ($urandom_range(0, 2) != 0);
      step();
      checks++;
      if (pe !== e_pe || ne !== e_ne || wait_n !== e_wait || irq !== e_irq) begin
        errors++;
        $display("FAIL rand k=%0d got pe%b ne%b w%b i%b exp pe%b ne%b w%b i%b",
                 k, pe, ne, wait_n, irq, e_pe, e_ne, e_wait, e_irq);
      end
    end
    reset = 1'b0; hold = 1'b0; irq_req = 1'b0;
    mreq = 1'b1; rfsh = 1'b1; iorq = 1'b1; m1 = 1'b1;
  endtask

  initial begin
    #1;
    test_reset();
    test_divider();
    test_hold();
    test_wait();
    test_irq_timeout();
    test_irq_ack();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_bus_seq.md
Name: cpu_bus_seq

Overview:
- Parametrised CPU bus sequencer for the T80-class core. Replaces fixed external clock enables and tied-off WAIT_n/INT_n.
- Generates the CPU's positive and negative clock enables from the master clock, with a programmable divider and contention hold.
- Inserts per-cycle-type wait states from the CPU's active-low strobes.
- Shapes a frame interrupt request into a bounded, acknowledge-cleared INT_n.

Parameters:
- DIV, 4, master clocks per CPU T-state; even, >=2
- MEM_WAIT, 0, wait T-states inserted per memory read/write cycle (0..15)
- IO_WAIT, 1, wait T-states inserted per I/O cycle (0..15)
- IRQ_LEN, 32, maximum INT_n low time in T-states (pe ticks), 1..255

Ports:
- clock  in  1  master clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- hold  in  1  contention; high freezes the divider and suppresses pe/ne
- irq_req  in  1  one-clock active-high interrupt request pulse
- mreq  in  1  CPU MREQ_n, active-low
- iorq  in  1  CPU IORQ_n, active-low
- m1  in  1  CPU M1_n, active-low
- rfsh  in  1  CPU RFSH_n, active-low
- pe  out  1  CPU positive clock enable (CEN_p), one-clock pulse
- ne  out  1  CPU negative clock enable (CEN_n), one-clock pulse
- wait_n  out  1  CPU WAIT_n, active-low
- irq  out  1  CPU INT_n, active-low

Behaviour:
- Reset (any cycle, including mid-wait or mid-interrupt): cnt=0, pe=0, ne=0, wait_n=1, irq=1, pending=0, wcnt=0, icnt=0, previous-strobe regs=1.
- Divider: cnt has $clog2(DIV) bits.
  - When hold=0: cnt wraps DIV-1 -> 0, otherwise increments.
  - When hold=1: cnt is held.
- pe and ne are registered.
  - pe <= ~hold & (cnt==DIV-1).
  - ne <= ~hold & (cnt==DIV/2-1).
  - First ne is high after the 2nd edge following reset release (DIV=4); first pe after the 4th edge. Pulses are exactly one clock wide.
- Wait states: all evaluation happens on clocks where pe=1 ("tick"); strobes are also sampled into previous-strobe regs on ticks.
  - Memory cycle start: mreq=0, rfsh=1, prev mreq=1. Load wcnt=MEM_WAIT.
  - I/O cycle start: iorq=0, m1=1, prev iorq=1. Load wcnt=IO_WAIT.
  - Refresh and interrupt-acknowledge cycles load nothing.
  - Otherwise, if wcnt!=0, wcnt decrements on each tick.
  - wait_n is registered: wait_n <= (next wcnt==0), updated only on ticks, so it is stable across ne.
  - A zero parameter value never drives wait_n low.
  - Hold does not affect wcnt except by withholding ticks.
- Interrupt:
  - irq_req=1 sets pending=1, icnt=IRQ_LEN.
  - irq = ~pending (registered).
  - On each tick while pending: icnt decrements; at icnt reaching 0, pending clears.
  - Acknowledge (m1=0 and iorq=0, checked every clock) clears pending.
  - Simultaneous irq_req and ack in the same clock: request wins (pending stays 1, icnt reloaded).
  - irq_req while already pending: icnt reloaded to IRQ_LEN.
- Simultaneous I/O start and ack: ack cycle (m1=0) is not an I/O start, so no wait states are loaded.

Optional Feature:
- Macro: CPU_BUS_SEQ_TURBO_EN
- With macro defined:
  - Extra input turbo (1 bit, after hold). When turbo=1, the effective period is DIV/2: pe at cnt==DIV/2-1, ne at cnt==DIV/4-1, and cnt wraps at DIV/2-1.
  - turbo is sampled only when cnt==0, so the mode changes on a period boundary.
  - DIV must be divisible by 4.
  - Wait-state counts are unchanged in T-states.
- Without macro: no turbo port; period is always DIV.

Test Plan:
- Divider: DIV=4, hold=0 for 16 clocks after reset -> pe high after edges 4, 8, 12, 16; ne after edges 2, 6, 10, 14; never both high together.
- Hold: assert hold for 6 clocks mid-period -> no pe/ne during hold; cnt frozen; spacing resumes unchanged after release.
- Wait states: MEM_WAIT=2, drive a memory read (mreq low, rfsh high) -> wait_n low for exactly 2 ticks, then high. A refresh cycle (mreq=0, rfsh=0) -> wait_n stays 1. IO_WAIT=1 on an I/O cycle -> exactly 1 tick low.
- Interrupt timeout: IRQ_LEN=8, irq_req pulse, no ack -> irq low from the next clock for 8 ticks, then high.
- Interrupt ack and reset: irq_req then m1=0, iorq=0 after 3 ticks -> irq high the next clock. irq_req coincident with ack -> irq stays low. Reset mid-wait -> wait_n=1 and irq=1 the next clock.
